imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
Registered, flow-controlled immediate generator for the decode stage; successor to the combinational immediate extender.
- Parametrised in datapath width (RV32/RV64) and adds CSR zimm support.
- Carries a sideband tag (PC / ROB index) alongside each immediate.
- Valid/ready on both sides with a 2-entry skid buffer, so backpressure from execute never drops or reorders instructions.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 32, width of sideband tag passed through unchanged.

Ports:
CLK  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
InValid  input  1  upstream has an instruction.
InReady  output  1  block can accept; registered.
Instr  input  32  raw instruction word.
InstrType  input  3  immediate format code (package encoding).
InTag  input  TAG_W  sideband tag.
OutValid  output  1  ExtImm/OutTag/OutType valid.
OutReady  input  1  downstream accepts.
ExtImm  output  XLEN  extended immediate.
OutTag  output  TAG_W  tag of the same instruction.
OutType  output  3  InstrType of the same instruction.
IllegalType  output  1  present only with IMM_ILLEGAL_CHK_EN.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is asynchronous and active-high.
- Reset values: OutValid=0, ExtImm=0, OutTag=0, OutType=0, IllegalType=0, skid empty, InReady=1.
- Reset asserted mid-operation discards both entries immediately.
- Format rules; sign-extension is always from Instr[31] up to XLEN:
  - RS: zero-extended shamt. XLEN=32 uses Instr[24:20]; XLEN=64 uses Instr[25:20].
  - I: sext(Instr[31:20]).
  - S: sext({Instr[31:25],Instr[11:7]}).
  - B: sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}).
  - U: sext({Instr[31:12],12'b0}). Sign-extends for XLEN=64.
  - J: sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}).
  - Z: zero-extended Instr[19:15] (CSR zimm).
  - Code 7 (reserved): ExtImm=0.
- Storage: an output register (Out) plus one skid register (Skid).
- Transfer rules:
  - An input transfer occurs when InValid&&InReady at a rising edge.
  - An output transfer occurs when OutValid&&OutReady.
- Input transfer, by state at the edge:
  - Out empty, or output transfer in the same cycle, and Skid empty: Out <= new. Latency is 1 cycle: the result is visible the cycle after acceptance.
  - Out full, no output transfer: Skid <= new; InReady deasserts next cycle.
- Skid full and output transfer: Out <= Skid, Skid clears, InReady reasserts next cycle.
  - InReady is low while Skid is full, so no new input can arrive that cycle.
- InReady = !SkidValid (registered). It must not depend combinationally on OutReady.
- While OutValid&&!OutReady, all Out fields hold stable.
- Order is strictly FIFO. Sustained throughput is 1/cycle when OutReady=1.
- InValid low: no state change except draining.
- Instr/InstrType/InTag are ignored when InValid=0.

Optional Feature:
IMM_ILLEGAL_CHK_EN.
- Defined: the IllegalType port exists and is registered with the entry. It is 1 when InstrType=7, or when XLEN=32 and RS-type has Instr[25]=1 (invalid RV32 shamt). It is valid only with OutValid. ExtImm=0 for these cases.
- Undefined: the port is absent, no check logic is built, and code 7 yields ExtImm=0 silently.

Decomposition:
- Shared package: InstrType encoding constants RS=0, I=1, S=2, B=3, U=4, J=5, Z=6, RSV=7.
  - The encoding is shared with the decoder and control unit.
- Sub-module imm_extend_comb: purely combinational Instr/InstrType -> XLEN immediate (plus illegal flag when enabled).
  - The top level owns only the skid/handshake registers.

Test Plan:
- XLEN=32, I, Instr=0xFFF00093, OutReady=1 -> next cycle OutValid=1, ExtImm=0xFFFFFFFF, OutTag=InTag.
- XLEN=32, B, Instr=0xFE000EE3 -> ExtImm=0xFFFFFFFC. U, Instr=0x12345037 -> ExtImm=0x12345000.
- XLEN=64: U, Instr=0x800000B7 -> ExtImm=0xFFFFFFFF80000000. RS, Instr with [25:20]=6'b100001 -> ExtImm=33. Z, Instr[19:15]=5'h1F -> ExtImm=31.
- Backpressure: OutReady=0, present tags A, B, C back-to-back.
  - A sits in Out, B in Skid; InReady=0 the cycle after B is accepted; C is held.
  - Then OutReady=1 -> outputs A, B, C in consecutive cycles, no loss or duplicate.
- Reset asserted asynchronously with both entries full -> OutValid=0, InReady=1 without waiting for a clock edge; no stale output after release.
- With IMM_ILLEGAL_CHK_EN, XLEN=32: InstrType=7 -> IllegalType=1, ExtImm=0. RS with Instr[25]=1 -> IllegalType=1. Legal I-type -> IllegalType=0.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// Shared immediate-format encoding for the decoder, control unit and immediate generator.
package imm_extend_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_RS  = 3'd0,
    IMM_I   = 3'd1,
    IMM_S   = 3'd2,
    IMM_B   = 3'd3,
    IMM_U   = 3'd4,
    IMM_J   = 3'd5,
    IMM_Z   = 3'd6,
    IMM_RSV = 3'd7
  } imm_type_e;

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational instruction-word to XLEN immediate extender.
// Optional IMM_ILLEGAL_CHK_EN adds the illegal-format flag.
module imm_extend_comb
  import imm_extend_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      instr_type,
`ifdef IMM_ILLEGAL_CHK_EN
  output logic            illegal,
`endif
  output logic [XLEN-1:0] imm
);

  imm_type_e  fmt;
  logic [31:0] raw;
  logic        rs_bad;
  logic        unused_opcode;

  assign fmt           = imm_type_e'(instr_type);
  assign unused_opcode = ^instr[6:0];
  // A 6-bit shift amount with the top bit set is meaningless on RV32.
  assign rs_bad        = (XLEN == 32) && instr[25];

  // NOTE: raw gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    raw = '0;
    case (fmt)
      IMM_RS: begin
        if (XLEN == 64) raw = {26'b0, instr[25:20]};
        else            raw = {27'b0, instr[24:20]};
`ifdef IMM_ILLEGAL_CHK_EN
        if (rs_bad) raw = '0;
`endif
      end
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   raw = {27'b0, instr[19:15]};
      IMM_RSV: raw = '0;
      default: raw = '0;
    endcase
  end

  // raw[31] already carries the sign (zero for the zero-extended formats).
  assign imm = {{(XLEN-31){raw[31]}}, raw[30:0]};

`ifdef IMM_ILLEGAL_CHK_EN
  assign illegal = (fmt == IMM_RSV) || ((fmt == IMM_RS) && rs_bad);
`else
  logic unused_rs_bad;
  assign unused_rs_bad = rs_bad;
`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with valid/ready and a 2-entry skid buffer.
// Define IMM_ILLEGAL_CHK_EN to add the IllegalType output.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [2:0]       InstrType,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ExtImm,
  output logic [TAG_W-1:0] OutTag,
`ifdef IMM_ILLEGAL_CHK_EN
  output logic             IllegalType,
`endif
  output logic [2:0]       OutType
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic [2:0]       itype;
`ifdef IMM_ILLEGAL_CHK_EN
    logic             ill;
`endif
  } entry_t;

  entry_t new_e, out_q, skid_q;
  logic   out_valid, skid_valid;
  logic   in_fire, out_fire;

  imm_extend_comb #(.XLEN(XLEN)) u_comb (
    .instr      (Instr),
    .instr_type (InstrType),
`ifdef IMM_ILLEGAL_CHK_EN
    .illegal    (new_e.ill),
`endif
    .imm        (new_e.imm)
  );

  assign new_e.tag   = InTag;
  assign new_e.itype = InstrType;

  // InReady comes straight from a flop, never from OutReady.
  assign InReady  = !skid_valid;
  assign in_fire  = InValid && InReady;
  assign out_fire = out_valid && OutReady;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
    end else if (skid_valid) begin
      if (out_fire) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid || out_fire) begin
        out_q     <= new_e;
        out_valid <= 1'b1;
      end else begin
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid, so only the valid flag needs a reset.
  always_ff @(posedge CLK) begin
    if (in_fire && out_valid && !out_fire) skid_q <= new_e;
  end

  assign OutValid = out_valid;
  assign ExtImm   = out_q.imm;
  assign OutTag   = out_q.tag;
  assign OutType  = out_q.itype;
`ifdef IMM_ILLEGAL_CHK_EN
  assign IllegalType = out_q.ill;
`endif

endmodule
